coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Sequential front end that collects customer coins one per cycle, tracks the coin inventory, and presents the settled Paid/Cost pair to the combinational change-dispensing block.
- Coins flow in here; change coins flow out downstream.
- On acknowledgement, it debits the two coins the change block dispensed from the inventory.

Parameters:
- INIT_P, 1, pentagon count loaded at reset (0..3)
- INIT_T, 1, triangle count loaded at reset (0..3)
- INIT_C, 2, circle count loaded at reset (0..3)

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, no other clock domains
- Start  input  1  begin transaction; sampled only in IDLE
- Cost  input  4  item cost, latched on accepted Start
- CoinValid  input  1  coin presented this cycle
- CoinType  input  2  00 = invalid, 01 = circle (1), 10 = triangle (3), 11 = pentagon (5)
- VendAck  input  1  change block has consumed Paid/CostOut; sampled only in VEND
- FirstCoin  input  3  value of first dispensed coin (0/1/3/5), valid with VendAck
- SecondCoin  input  3  value of second dispensed coin (0/1/3/5), valid with VendAck
- Paid  output  4  accumulated payment
- CostOut  output  4  latched cost
- PaidValid  output  1  high throughout VEND
- Pentagons  output  2  current pentagon inventory
- Triangles  output  2  current triangle inventory
- Circles  output  2  current circle inventory
- CoinAccept  output  1  registered one-cycle pulse: the coin of the previous cycle was taken
- CoinReject  output  1  registered one-cycle pulse: the coin of the previous cycle was returned
- Busy  output  1  state != IDLE

Behaviour:
- Reset values: state = IDLE; Paid = 0; CostOut = 0; PaidValid = 0; CoinAccept = 0; CoinReject = 0; Busy = 0; inventory = INIT_P / INIT_T / INIT_C.
- Reset mid-transaction aborts the transaction. Inventory also reloads from the parameters.
- States: IDLE, COLLECT, VEND.
- IDLE:
  - Start = 1 → CostOut <= Cost, Paid <= 0, next state COLLECT.
  - A coin presented in IDLE is rejected.
- COLLECT, when registered Paid >= CostOut:
  - Next state VEND (one cycle after the satisfying coin edge).
  - Any coin presented that cycle is rejected.
  - Cost = 0 therefore reaches VEND two cycles after Start.
- COLLECT, otherwise, a coin is accepted iff all of the following hold:
  - CoinValid = 1
  - CoinType != 00
  - inventory of that type < 3
  - Paid + value <= 15, computed 5 bits wide
- Accepted coin: Paid <= Paid + value; inventory of that type +1; CoinAccept = 1 next cycle.
- Any presented coin not accepted: CoinReject = 1 next cycle; Paid and inventory unchanged.
- CoinAccept and CoinReject are never high together. Both are 0 when CoinValid = 0.
- VEND:
  - PaidValid = 1; Paid and CostOut held.
  - VendAck = 1 → for each of FirstCoin and SecondCoin, decrement the matching inventory (5 → P, 3 → T, 1 → C, 0 → none).
  - Two coins of the same type decrement that count by 2. Counts saturate at 0.
  - Other codes (2, 4, 6, 7) are ignored.
  - On the same VendAck edge: Paid <= 0, next state IDLE.
  - Coins presented in VEND are rejected.
- Start outside IDLE is ignored. VendAck outside VEND is ignored.

Optional Feature:
- Macro: COIN_ACCEPTOR_CANCEL_EN.
- When defined:
  - Extra input port Cancel (1 bit).
  - Cancel = 1 in COLLECT → next state VEND with CostOut <= 0, so the change block refunds all of Paid. A coin presented that same cycle is rejected.
  - Cancel has priority over the Paid >= CostOut transition.
- When undefined: no Cancel port; COLLECT exits only via Paid >= CostOut.

Test Plan:
- Reset; Start with Cost = 7; coins 5, then 3 → CoinAccept pulses twice; Paid = 8; PaidValid high on the 2nd cycle after the 3-coin edge; Pentagons = 2, Triangles = 2.
- In VEND (Paid = 8, CostOut = 7): VendAck with FirstCoin = 1, SecondCoin = 0 → Circles 2 → 1; Paid = 0; state IDLE; Busy = 0 next cycle.
- Inventory saturation: Triangles = 3, Cost = 9; present triangle → CoinReject = 1, Paid unchanged; then pentagon + pentagon → Paid = 10, VEND.
- Overflow guard: Cost = 15, Paid = 13; present pentagon (18 > 15) → CoinReject; circle → Paid = 14, stays COLLECT.
- VendAck with FirstCoin = 1, SecondCoin = 1 while Circles = 1 → Circles = 0 (saturated). CoinType = 00 in COLLECT → CoinReject.
- With COIN_ACCEPTOR_CANCEL_EN: Cost = 9, pay 3, assert Cancel → VEND with CostOut = 0, Paid = 3. Reset asserted in COLLECT → all outputs at reset values next cycle.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: takes coins one per cycle, tracks inventory and hands Paid/Cost to the change block.
// Optional COIN_ACCEPTOR_CANCEL_EN adds a Cancel input that refunds the whole payment.
module coin_acceptor #(
  parameter int INIT_P = 1,
  parameter int INIT_T = 1,
  parameter int INIT_C = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Start,
  input  logic [3:0] Cost,
  input  logic       CoinValid,
  input  logic [1:0] CoinType,
  input  logic       VendAck,
  input  logic [2:0] FirstCoin,
  input  logic [2:0] SecondCoin,
`ifdef COIN_ACCEPTOR_CANCEL_EN
  input  logic       Cancel,
`endif
  output logic [3:0] Paid,
  output logic [3:0] CostOut,
  output logic       PaidValid,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  output logic       CoinAccept,
  output logic       CoinReject,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2
  } state_t;

  state_t     state, stateNext;
  logic [3:0] paid, paidNext;
  logic [3:0] costReg, costNext;
  logic [1:0] pentCount, pentNext;
  logic [1:0] triCount, triNext;
  logic [1:0] circCount, circNext;
  logic       acceptReg, acceptNext;
  logic       rejectReg, rejectNext;

  logic [3:0] coinValue;
  logic [1:0] typeCount;
  logic [4:0] sum5;
  logic       canTake;

  // Dispensed coins may both be of one type, so the debit can be 2; never wrap below 0.
  function automatic logic [1:0] debit(input logic [1:0] cnt, input logic [2:0] a,
                                       input logic [2:0] b, input logic [2:0] code);
    logic [1:0] n;
    n = {1'b0, (a == code)} + {1'b0, (b == code)};
    return (cnt > n) ? (cnt - n) : 2'd0;
  endfunction

  always_comb begin
    coinValue = 4'd0;
    typeCount = 2'd3;
    case (CoinType)
      2'b01: begin coinValue = 4'd1; typeCount = circCount; end
      2'b10: begin coinValue = 4'd3; typeCount = triCount;  end
      2'b11: begin coinValue = 4'd5; typeCount = pentCount; end
      default: begin coinValue = 4'd0; typeCount = 2'd3; end
    endcase
  end

  // Sum is one bit wider so an overflowing coin is seen rather than wrapping.
  assign sum5    = {1'b0, paid} + {1'b0, coinValue};
  assign canTake = CoinValid && (CoinType != 2'b00) && (typeCount < 2'd3) && (sum5 <= 5'd15);

  always_comb begin
    stateNext  = state;
    paidNext   = paid;
    costNext   = costReg;
    pentNext   = pentCount;
    triNext    = triCount;
    circNext   = circCount;
    acceptNext = 1'b0;
    rejectNext = 1'b0;
    case (state)
      IDLE: begin
        rejectNext = CoinValid;
        if (Start) begin
          costNext  = Cost;
          paidNext  = 4'd0;
          stateNext = COLLECT;
        end
      end
      COLLECT: begin
`ifdef COIN_ACCEPTOR_CANCEL_EN
        if (Cancel) begin
          costNext   = 4'd0;
          stateNext  = VEND;
          rejectNext = CoinValid;
        end else
`endif
        if (paid >= costReg) begin
          stateNext  = VEND;
          rejectNext = CoinValid;
        end else if (CoinValid) begin
          if (canTake) begin
            paidNext   = sum5[3:0];
            acceptNext = 1'b1;
            case (CoinType)
              2'b01:   circNext = circCount + 2'd1;
              2'b10:   triNext  = triCount + 2'd1;
              2'b11:   pentNext = pentCount + 2'd1;
              default: circNext = circCount;
            endcase
          end else begin
            rejectNext = 1'b1;
          end
        end
      end
      VEND: begin
        rejectNext = CoinValid;
        if (VendAck) begin
          pentNext  = debit(pentCount, FirstCoin, SecondCoin, 3'd5);
          triNext   = debit(triCount, FirstCoin, SecondCoin, 3'd3);
          circNext  = debit(circCount, FirstCoin, SecondCoin, 3'd1);
          paidNext  = 4'd0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      paid      <= 4'd0;
      costReg   <= 4'd0;
      pentCount <= 2'(INIT_P);
      triCount  <= 2'(INIT_T);
      circCount <= 2'(INIT_C);
      acceptReg <= 1'b0;
      rejectReg <= 1'b0;
    end else begin
      state     <= stateNext;
      paid      <= paidNext;
      costReg   <= costNext;
      pentCount <= pentNext;
      triCount  <= triNext;
      circCount <= circNext;
      acceptReg <= acceptNext;
      rejectReg <= rejectNext;
    end
  end

  assign Paid       = paid;
  assign CostOut    = costReg;
  assign PaidValid  = (state == VEND);
  assign Busy       = (state != IDLE);
  assign Pentagons  = pentCount;
  assign Triangles  = triCount;
  assign Circles    = circCount;
  assign CoinAccept = acceptReg;
  assign CoinReject = rejectReg;

endmodule
